// File: rtl/unidir_bus_rr_pkg.sv
// Shared definitions for the unidirectional bus blocks: ID-width helper
// and the bus-ID width macro built on it.
`ifndef UNIDIR_BUS_RR_PKG_SV
`define UNIDIR_BUS_RR_PKG_SV

package unidir_bus_rr_pkg;

    // Ceiling log2 with a floor of 1 so a two-source bus still gets a 1-bit ID.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`define UBR_ID_W(n) unidir_bus_rr_pkg::clog2_min1(n)

`endif

// File: rtl/unidir_bus_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr upwards with explicit
// wrap at NSRC-1, so IDs >= NSRC are never produced.
module rr_arbiter
    import unidir_bus_rr_pkg::*;
#(
    parameter  int NSRC  = 4,
    localparam int SRC_W = `UBR_ID_W(NSRC)
) (
    input  logic [NSRC-1:0]  req,
    input  logic [SRC_W-1:0] ptr,
    input  logic             enable,
    output logic [NSRC-1:0]  gnt,
    output logic [SRC_W-1:0] gnt_idx,
    output logic             any_gnt
);

    logic [SRC_W:0] idx_s;
    logic           found_s;

    // Priority scan starting at ptr; first requester wins, grant gated by enable.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < NSRC; k++) begin
            idx_s = {1'b0, ptr} + (SRC_W+1)'(k);
            if (idx_s >= (SRC_W+1)'(NSRC)) begin
                idx_s = idx_s - (SRC_W+1)'(NSRC);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req[idx_s[SRC_W-1:0]]) begin
                found_s = 1'b1;
                gnt_idx = idx_s[SRC_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
        any_gnt = found_s & enable;
        if (any_gnt) begin
            gnt[gnt_idx] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/unidir_bus_rr.sv
// Multi-source unidirectional bus: round-robin arbitration onto one registered
// output word with valid/ready on both sides and a wrapping transfer counter.
module unidir_bus_rr
    import unidir_bus_rr_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int NSRC  = 4,
    parameter  int CNT_W = 16,
    localparam int SRC_W = `UBR_ID_W(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NSRC-1:0]       src_valid,
    input  logic [NSRC*WIDTH-1:0] src_data,
    output logic [NSRC-1:0]       src_ready,
    output logic                  bus_valid,
    output logic [WIDTH-1:0]      bus_data,
    output logic [SRC_W-1:0]      bus_src,
    input  logic                  bus_ready,
    output logic [CNT_W-1:0]      xfer_count
);

    logic             load_en_s;
    logic [NSRC-1:0]  gnt_s;
    logic [SRC_W-1:0] gnt_idx_s;
    logic             any_gnt_s;
    logic [SRC_W-1:0] ptr_next_s;
    logic [WIDTH-1:0] win_data_s;

    logic             bus_valid_r;
    logic [WIDTH-1:0] bus_data_r;
    logic [SRC_W-1:0] bus_src_r;
    logic [SRC_W-1:0] ptr_r;
    logic [CNT_W-1:0] xfer_r;

    // A new word may load only when the bus slot is free or retiring this cycle.
    always_comb begin
        load_en_s = en & (~bus_valid_r | bus_ready) & ~rst;
    end

    rr_arbiter #(.NSRC(NSRC)) u_arb (
        .req     (src_valid),
        .ptr     (ptr_r),
        .enable  (load_en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any_gnt (any_gnt_s)
    );

    // Winner data mux and pointer advance with explicit wrap for non-power-of-two NSRC.
    always_comb begin
        win_data_s = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (gnt_idx_s == SRC_W'(i)) begin
                win_data_s = src_data[i*WIDTH +: WIDTH];
            end else begin
                win_data_s = win_data_s;
            end
        end
        if (gnt_idx_s == SRC_W'(NSRC-1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = gnt_idx_s + SRC_W'(1);
        end
    end

    // Bus word, pointer and transfer counter; idle bus is forced to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_valid_r <= 1'b0;
            bus_data_r  <= '0;
            bus_src_r   <= '0;
            ptr_r       <= '0;
            xfer_r      <= '0;
        end else begin
            if (bus_valid_r & bus_ready) begin
                xfer_r <= xfer_r + CNT_W'(1);
            end else begin
                xfer_r <= xfer_r;
            end
            if (any_gnt_s) begin
                bus_valid_r <= 1'b1;
                bus_data_r  <= win_data_s;
                bus_src_r   <= gnt_idx_s;
                ptr_r       <= ptr_next_s;
            end else if (~bus_valid_r | bus_ready) begin
                bus_valid_r <= 1'b0;
                bus_data_r  <= '0;
                bus_src_r   <= bus_src_r;
                ptr_r       <= ptr_r;
            end else begin
                bus_valid_r <= bus_valid_r;
                bus_data_r  <= bus_data_r;
                bus_src_r   <= bus_src_r;
                ptr_r       <= ptr_r;
            end
        end
    end

    assign src_ready  = gnt_s;
    assign bus_valid  = bus_valid_r;
    assign bus_data   = bus_data_r;
    assign bus_src    = bus_src_r;
    assign xfer_count = xfer_r;

endmodule

// File: tb/tb_unidir_bus_rr.sv
// Self-checking bench for unidir_bus_rr (NSRC=4, WIDTH=4, CNT_W=4): a
// reference model scoreboards every accepted word, tasks check scenarios.
module tb_unidir_bus_rr;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  src_valid;
    logic [15:0] src_data;
    logic [3:0]  src_ready;
    logic        bus_valid;
    logic [3:0]  bus_data;
    logic [1:0]  bus_src;
    logic        bus_ready;
    logic [3:0]  xfer_count;

    int checks   = 0;
    int failures = 0;
    int n_pops   = 0;

    logic [5:0] sb[$];
    logic       m_valid;
    int         m_ptr;
    logic [3:0] m_cnt;

    unidir_bus_rr #(.WIDTH(4), .NSRC(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .bus_valid  (bus_valid),
        .bus_data   (bus_data),
        .bus_src    (bus_src),
        .bus_ready  (bus_ready),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        logic       ld;
        int         w;
        logic [3:0] exp_rdy;
        logic [5:0] exp_w;
        if (rst) begin
            sb.delete();
            m_valid = 1'b0;
            m_ptr   = 0;
            m_cnt   = 4'd0;
            checks++;
            if (src_ready !== 4'b0000) begin
                failures++;
                $display("FAIL rst_src_ready got=%b exp=0000", src_ready);
            end
        end else begin
            checks++;
            if (bus_valid !== m_valid) begin
                failures++;
                $display("FAIL mon_bus_valid got=%b exp=%b t=%0t", bus_valid, m_valid, $time);
            end
            if (!m_valid) begin
                checks++;
                if (bus_data !== 4'h0) begin
                    failures++;
                    $display("FAIL mon_idle_data got=%h exp=0 t=%0t", bus_data, $time);
                end
            end
            checks++;
            if (xfer_count !== m_cnt) begin
                failures++;
                $display("FAIL mon_xfer_count got=%0d exp=%0d t=%0t", xfer_count, m_cnt, $time);
            end
            if (m_valid && bus_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow got=%b/%h exp=empty", bus_src, bus_data);
                end else begin
                    exp_w = sb.pop_front();
                    n_pops++;
                    if ({bus_src, bus_data} !== exp_w) begin
                        failures++;
                        $display("FAIL sb_word got=src%0d:%h exp=src%0d:%h t=%0t",
                                 bus_src, bus_data, exp_w[5:4], exp_w[3:0], $time);
                    end
                end
                m_cnt = m_cnt + 4'd1;
            end
            ld      = en && (!m_valid || bus_ready);
            w       = rr_pick(src_valid, m_ptr);
            exp_rdy = (ld && w >= 0) ? (4'b0001 << w) : 4'b0000;
            checks++;
            if (src_ready !== exp_rdy) begin
                failures++;
                $display("FAIL mon_src_ready got=%b exp=%b t=%0t", src_ready, exp_rdy, $time);
            end
            if (ld && w >= 0) begin
                sb.push_back({2'(w), src_data[w*4 +: 4]});
                m_valid = 1'b1;
                m_ptr   = (w + 1) % 4;
            end else if (!m_valid || bus_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [3:0] d);
        src_valid[i]       = v;
        src_data[i*4 +: 4] = d;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        bus_ready = 1'b0;
        src_valid = 4'b0000;
        src_data  = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        en = 1'b1;
        tick();
        checks++;
        if (bus_valid !== 1'b0 || bus_data !== 4'h0 || xfer_count !== 4'd0 || src_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle got=v%b d%h c%0d r%b exp=v0 d0 c0 r0000",
                     bus_valid, bus_data, xfer_count, src_ready);
        end
    endtask

    task automatic test_sweep();
        int p0;
        p0 = n_pops;
        bus_ready = 1'b1;
        for (int v = 0; v < 16; v++) begin
            en = 1'b0;
            set_src(2, 1'b1, 4'(v));
            #1;
            checks++;
            if (src_ready !== 4'b0000) begin
                failures++;
                $display("FAIL sweep_en0_ready got=%b exp=0000 v=%0d", src_ready, v);
            end
            if (v > 0) begin
                checks++;
                if (bus_valid !== 1'b1 || bus_data !== 4'(v-1) || bus_src !== 2'd2) begin
                    failures++;
                    $display("FAIL sweep_word got=v%b d%h s%0d exp=v1 d%h s2",
                             bus_valid, bus_data, bus_src, 4'(v-1));
                end
            end
            tick();
            en = 1'b1;
            #1;
            checks++;
            if (src_ready !== 4'b0100 || bus_valid !== 1'b0 || bus_data !== 4'h0) begin
                failures++;
                $display("FAIL sweep_accept got=r%b v%b d%h exp=r0100 v0 d0",
                         src_ready, bus_valid, bus_data);
            end
            tick();
        end
        src_valid = 4'b0000;
        en = 1'b0;
        tick();
        checks++;
        if (bus_valid !== 1'b0 || xfer_count !== 4'd0 || (n_pops - p0) != 16) begin
            failures++;
            $display("FAIL sweep_total got=v%b c%0d pops%0d exp=v0 c0 pops16",
                     bus_valid, xfer_count, n_pops - p0);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_d;
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 4'hA + 4'(i));
        en = 1'b1;
        bus_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_d = 4'hA + 4'(k % 4);
            checks++;
            if (bus_valid !== 1'b1 || bus_src !== 2'(k % 4) || bus_data !== exp_d) begin
                failures++;
                $display("FAIL rr_order k=%0d got=v%b s%0d d%h exp=v1 s%0d d%h",
                         k, bus_valid, bus_src, bus_data, k % 4, exp_d);
            end
        end
        src_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        en = 1'b1;
        set_src(1, 1'b1, 4'h5);
        tick();
        src_valid[1] = 1'b0;
        set_src(3, 1'b1, 4'h9);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus_valid !== 1'b1 || bus_data !== 4'h5 || bus_src !== 2'd1 || src_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold k=%0d got=v%b d%h s%0d r%b exp=v1 d5 s1 r0000",
                         k, bus_valid, bus_data, bus_src, src_ready);
            end
            tick();
        end
        bus_ready = 1'b1;
        #1;
        checks++;
        if (src_ready !== 4'b1000) begin
            failures++;
            $display("FAIL bp_release_ready got=%b exp=1000", src_ready);
        end
        tick();
        src_valid[3] = 1'b0;
        checks++;
        if (bus_valid !== 1'b1 || bus_data !== 4'h9 || bus_src !== 2'd3) begin
            failures++;
            $display("FAIL bp_no_bubble got=v%b d%h s%0d exp=v1 d9 s3", bus_valid, bus_data, bus_src);
        end
        tick();
    endtask

    task automatic test_en_midstream();
        do_reset();
        en = 1'b1;
        set_src(0, 1'b1, 4'h7);
        tick();
        en = 1'b0;
        set_src(0, 1'b0, 4'h0);
        set_src(1, 1'b1, 4'h1);
        set_src(2, 1'b1, 4'h2);
        tick();
        tick();
        checks++;
        if (bus_valid !== 1'b1 || bus_data !== 4'h7 || src_ready !== 4'b0000) begin
            failures++;
            $display("FAIL en_hold got=v%b d%h r%b exp=v1 d7 r0000", bus_valid, bus_data, src_ready);
        end
        bus_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus_valid !== 1'b0 || bus_data !== 4'h0 || src_ready !== 4'b0000) begin
            failures++;
            $display("FAIL en_retire got=v%b d%h r%b exp=v0 d0 r0000", bus_valid, bus_data, src_ready);
        end
        en = 1'b1;
        #1;
        checks++;
        if (src_ready !== 4'b0010) begin
            failures++;
            $display("FAIL en_resume_ptr got=%b exp=0010", src_ready);
        end
        tick();
        src_valid[1] = 1'b0;
        #1;
        checks++;
        if (bus_src !== 2'd1 || bus_data !== 4'h1 || src_ready !== 4'b0100) begin
            failures++;
            $display("FAIL en_resume_word got=s%0d d%h r%b exp=s1 d1 r0100", bus_src, bus_data, src_ready);
        end
        tick();
        src_valid[2] = 1'b0;
        tick();
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        en = 1'b1;
        bus_ready = 1'b1;
        set_src(0, 1'b1, 4'h3);
        repeat (17) tick();
        src_valid = 4'b0000;
        tick();
        checks++;
        if (xfer_count !== 4'd1) begin
            failures++;
            $display("FAIL cnt_wrap got=%0d exp=1", xfer_count);
        end
        bus_ready = 1'b0;
        set_src(1, 1'b1, 4'h4);
        tick();
        src_valid = 4'b0000;
        checks++;
        if (bus_valid !== 1'b1 || bus_src !== 2'd1) begin
            failures++;
            $display("FAIL pre_rst_hold got=v%b s%0d exp=v1 s1", bus_valid, bus_src);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus_valid !== 1'b0 || bus_data !== 4'h0 || bus_src !== 2'd0 || xfer_count !== 4'd0) begin
            failures++;
            $display("FAIL midop_rst got=v%b d%h s%0d c%0d exp=v0 d0 s0 c0",
                     bus_valid, bus_data, bus_src, xfer_count);
        end
        set_src(0, 1'b1, 4'h1);
        set_src(1, 1'b1, 4'h2);
        bus_ready = 1'b1;
        #1;
        checks++;
        if (src_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rst_ptr got=%b exp=0001", src_ready);
        end
        tick();
        src_valid = 4'b0000;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        bus_ready = 1'b0;
        src_valid = 4'b0000;
        src_data  = 16'h0000;
        test_reset();
        test_sweep();
        test_fairness();
        test_backpressure();
        test_en_midstream();
        test_wrap_and_reset();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/unidir_bus_rr.md
Name: unidir_bus_rr

Overview:
Parametrised multi-source unidirectional bus, the successor to the single-source 4-bit gated bus. NSRC sources, each WIDTH bits wide, compete for one registered output bus. Arbitration is round-robin, with valid/ready handshakes on both sides and a global enable. A wrapping transfer counter supports bus-utilisation checks.

Parameters:
WIDTH, 4, data width of each source and of the bus
NSRC, 4, number of sources (2..16)
CNT_W, 16, width of the transfer counter
SRC_W, derived = clog2(NSRC) (min 1), width of the source-ID field (localparam, not overridable)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
en  in  1  global bus enable; 0 = no new grants (legacy "c" control)
src_valid  in  NSRC  per-source request, bit i = source i
src_data  in  NSRC*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]
src_ready  out  NSRC  one-hot (or zero) grant/accept, combinational
bus_valid  out  1  output word valid
bus_data  out  WIDTH  output word
bus_src  out  SRC_W  index of the source that produced bus_data
bus_ready  in  1  sink accepts the word
xfer_count  out  CNT_W  count of completed bus transfers

Behaviour:
- Reset (rst=1 at a clk edge): bus_valid=0, bus_data=0, bus_src=0, xfer_count=0, round-robin pointer ptr=0. Any held word is dropped. src_ready=0 while rst=1.
- load_en = en & (~bus_valid | bus_ready) & ~rst.
- Winner: the first i with src_valid[i]=1, scanning ptr, ptr+1, ... NSRC-1, 0, ... ptr-1.
- src_ready[winner] = load_en. All other src_ready bits = 0. src_ready never depends on src_data.
- Source-side transfer happens when src_valid[i] & src_ready[i].
  - Next edge: bus_valid<=1, bus_data<=src_data[winner], bus_src<=winner, ptr<=(winner+1) mod NSRC.
  - Latency is 1 cycle from accept to bus_valid.
- If (~bus_valid | bus_ready) and no source transfers: bus_valid<=0 and bus_data<=0, so the idle bus reads zero. bus_src and ptr hold.
- Hold: while bus_valid=1 and bus_ready=0, bus_data and bus_src are stable and no source is accepted.
- Throughput: 1 word/cycle with bus_ready held at 1. Back-to-back transfers from the same source are allowed only when no other source requests.
- en=0:
  - No grants; src_ready=0.
  - A held word stays until bus_ready, then bus_valid<=0 and bus_data<=0.
  - ptr holds.
- Simultaneous bus_ready and a new accept in one cycle: the old word retires and the new word loads on the same edge (no bubble).
- xfer_count increments by 1 on each edge with bus_valid & bus_ready and wraps from 2^CNT_W-1 to 0. It is reset only by rst.
- Sources are expected to keep src_valid and src_data stable until accepted. The block does not check this.
- NSRC not a power of two: ptr wraps explicitly at NSRC-1. IDs >= NSRC are never produced.

Decomposition:
- Shared header/package: clog2 constant function, and a bus-ID width macro reused by the bus blocks.
- One sub-module, rr_arbiter (params NSRC).
  - Inputs: req, ptr, enable.
  - Outputs: one-hot gnt, gnt_idx, any_gnt.
  - Purely combinational.
  - ptr register and data register live in unidir_bus_rr.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then all src_valid=0, en=1 -> bus_valid=0, bus_data=0, xfer_count=0, src_ready=0000.
- Single source, legacy sweep: NSRC=4, WIDTH=4, src 2 drives 0..15, en toggles 0/1 every cycle, bus_ready=1 -> each value appears on bus_data with bus_src=2 exactly once, 1 cycle after accept; zero when idle; xfer_count=16.
- Round-robin fairness: all four src_valid=1 continuously, data = 4'hA,B,C,D, bus_ready=1 -> bus_src sequence 0,1,2,3,0,...; bus_data A,B,C,D repeating; one word per cycle.
- Backpressure: word 4'h5 from src 1 on bus, bus_ready=0 for 3 cycles -> bus_data=5 and bus_src=1 stable, src_ready=0000. When bus_ready=1 and src 3 valid with 4'h9, the next edge shows 9 with no bubble.
- en deassert mid-stream: en=0 while a word is held and sources are valid -> held word retires on bus_ready, then bus_valid=0; no grants until en=1, which resumes at the saved ptr.
- Counter wrap and mid-op reset: CNT_W=4, 17 transfers -> xfer_count=1. Then rst=1 with bus_valid=1 and bus_ready=0 -> next cycle bus_valid=0, ptr=0, count=0.
